// File: rtl/if_pc_bp_if.sv
// Fetch-PC control bundle: stall/redirect/BTB-update from the pipeline, PC and prediction back.
// Master drives the pipeline-side requests; slave is the PC block that owns o_pc_if.
interface if_pc_bp_if #(
  parameter int XLEN = 32
);
  logic            i_stall;
  logic            i_redirect_valid;
  logic [XLEN-1:0] i_redirect_pc;
  logic            i_btb_upd_valid;
  logic [XLEN-1:0] i_btb_upd_pc;
  logic [XLEN-1:0] i_btb_upd_target;
  logic            i_btb_upd_taken;
  logic [XLEN-1:0] o_pc_if;
  logic            o_pred_taken_if;
  logic [XLEN-1:0] o_pred_target_if;

  modport master (
    output i_stall, i_redirect_valid, i_redirect_pc,
    output i_btb_upd_valid, i_btb_upd_pc, i_btb_upd_target, i_btb_upd_taken,
    input  o_pc_if, o_pred_taken_if, o_pred_target_if
  );

  modport slave (
    input  i_stall, i_redirect_valid, i_redirect_pc,
    input  i_btb_upd_valid, i_btb_upd_pc, i_btb_upd_target, i_btb_upd_taken,
    output o_pc_if, o_pred_taken_if, o_pred_target_if
  );
endinterface

// File: rtl/if_pc_bp.sv
// Fetch PC with direct-mapped BTB and 2-bit counters; PC updates one cycle after inputs.
// i_stall holds the PC, i_redirect_valid overrides stall; prediction is combinational from state.
module if_pc_bp #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              BTB_ENTRIES  = 16,
  localparam int             IDX_W        = $clog2(BTB_ENTRIES)
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  if_pc_bp_if.slave   bus
);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [XLEN-1:0]  r_pc;
  logic             r_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] r_tag    [BTB_ENTRIES];
  logic [XLEN-3:0]  r_target [BTB_ENTRIES];
  logic [1:0]       r_ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic             w_pred_taken;
  logic [XLEN-1:0]  w_pred_target;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic [XLEN-1:0]  w_pc_next;
  logic             w_unused_ok;

  assign w_lk_idx      = r_pc[IDX_W+1:2];
  assign w_lk_tag      = r_pc[XLEN-1:IDX_W+2];
  assign w_lk_hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_pred_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
  assign w_pred_target = w_pred_taken ? {r_target[w_lk_idx], 2'b00} : '0;

  assign w_up_idx = bus.i_btb_upd_pc[IDX_W+1:2];
  assign w_up_tag = bus.i_btb_upd_pc[XLEN-1:IDX_W+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  // Low address bits are word-alignment only and never reach state.
  assign w_unused_ok = &{1'b0, bus.i_redirect_pc[1:0], bus.i_btb_upd_pc[1:0],
                         bus.i_btb_upd_target[1:0]};

  always_comb begin
    w_pc_next = r_pc + XLEN'(4);
    if (bus.i_redirect_valid) begin
      w_pc_next = {bus.i_redirect_pc[XLEN-1:2], 2'b00};
    end else if (bus.i_stall) begin
      w_pc_next = r_pc;
    end else if (w_pred_taken) begin
      w_pc_next = w_pred_target;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // Update sees pre-edge contents, so a same-index lookup this cycle is unaffected.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b00;
      end
    end else if (bus.i_btb_upd_valid) begin
      if (w_up_hit) begin
        if (bus.i_btb_upd_taken) begin
          r_target[w_up_idx] <= bus.i_btb_upd_target[XLEN-1:2];
          if (r_ctr[w_up_idx] != 2'b11) begin
            r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
          end
        end else if (r_ctr[w_up_idx] != 2'b00) begin
          r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
        end
      end else if (bus.i_btb_upd_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= bus.i_btb_upd_target[XLEN-1:2];
        r_ctr[w_up_idx]    <= 2'b10;
      end
    end
  end

  assign bus.o_pc_if          = r_pc;
  assign bus.o_pred_taken_if  = w_pred_taken;
  assign bus.o_pred_target_if = w_pred_target;
endmodule
